transaction_sequencer: RTL and testbench

Central controller between the UART receive path, the sensor decoder and the UART transmit path. It assembles two-byte requests (command, device address) from received bytes and validates the address. It then issues exactly one sensor transaction, guards it with a timeout, and serialises the two-byte reply (response code, data) into the transmitter. It also owns continuous-monitoring mode, re-issuing the stored request periodically until cancelled.

---
 rtl/transaction_sequencer_pkg.sv | 17 +
 rtl/transaction_sequencer_cycle_timer.sv | 19 +
 rtl/transaction_sequencer.sv | 131 +++++++++++++
 tb/tb_transaction_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/transaction_sequencer_pkg.sv
// transaction_sequencer_pkg: shared states, reply codes and frame constants
package transaction_sequencer_pkg;
    typedef enum logic [3:0] {
        IDLE, GET_ADDR, ISSUE, WAIT_SENSOR, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA, STREAM_WAIT
    } state_t;
    localparam logic [7:0] RESP_STOP_ACK = 8'hFD;
    localparam logic [7:0] RESP_BAD_ADDR = 8'hFE;
    localparam logic [7:0] RESP_TIMEOUT = 8'hFF;
    localparam logic [6:0] OPC_STOP = 7'h7F;
    localparam int STREAM_BIT = 7;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/transaction_sequencer_cycle_timer.sv
// cycle_timer: saturating up-counter with same-cycle clear and terminal-count compare
module cycle_timer #(
    parameter int W = 8
) (
    input logic clock,
    input logic reset,
    input logic clear,
    input logic enable,
    input logic [W-1:0] limit,
    output logic hit
);
    logic [W-1:0] count, cur;
    // clear makes the entry cycle read as count 0
    always_comb cur = clear ? '0 : count;
    assign hit = enable && cur == limit;
    always_ff @(posedge clock)
        if (reset || !enable) count <= '0;
        else count <= &cur ? cur : cur + 1'b1;
endmodule

// File: rtl/transaction_sequencer.sv
// transaction_sequencer: frames UART requests into sensor transactions and serialises replies
module transaction_sequencer
    import transaction_sequencer_pkg::*;
#(
    parameter int NUM_DEVICES = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int PERIOD_CYCLES = 50_000_000
) (
    input logic clock,
    input logic reset,
    input logic rx_valid,
    input logic [7:0] rx_data,
    output logic [31:0] device_selector,
    output logic [7:0] sensor_command,
    output logic sensor_start,
    input logic sensor_done,
    input logic [7:0] sensor_code,
    input logic [7:0] sensor_data,
    output logic tx_start,
    output logic [7:0] tx_data,
    input logic tx_busy,
    input logic tx_done,
    output logic busy,
    output logic stream_active,
    output logic rx_overrun
);
    localparam int TW = $clog2(max_int(max_int(TIMEOUT_CYCLES, PERIOD_CYCLES), 2));
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [8:0] DEV_LIMIT = 9'(NUM_DEVICES);

    state_t state, prev_state;
    logic [7:0] cmd, code, data;
    logic [4:0] addr;
    logic hit;

    cycle_timer #(.W(TW)) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(state != prev_state),
        .enable(state inside {GET_ADDR, WAIT_SENSOR, STREAM_WAIT}),
        .limit(state == STREAM_WAIT ? PER_LAST : TO_LAST),
        .hit(hit)
    );

    assign busy = !(state inside {IDLE, STREAM_WAIT});

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            prev_state <= IDLE;
            cmd <= '0;
            addr <= '0;
            code <= '0;
            data <= '0;
            device_selector <= '0;
            sensor_command <= '0;
            sensor_start <= 1'b0;
            tx_start <= 1'b0;
            tx_data <= '0;
            stream_active <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            prev_state <= state;
            sensor_start <= 1'b0;
            tx_start <= 1'b0;
            rx_overrun <= rx_valid && !(state inside {IDLE, GET_ADDR, STREAM_WAIT});
            case (state)
                IDLE: if (rx_valid) begin
                    cmd <= rx_data;
                    state <= GET_ADDR;
                end
                GET_ADDR: if (rx_valid) begin
                    addr <= rx_data[4:0];
                    data <= '0;
                    if (cmd[6:0] == OPC_STOP) begin
                        stream_active <= 1'b0;
                        code <= RESP_STOP_ACK;
                        state <= SEND_CODE;
                    end else if ({1'b0, rx_data} >= DEV_LIMIT) begin
                        stream_active <= 1'b0;
                        code <= RESP_BAD_ADDR;
                        state <= SEND_CODE;
                    end else begin
                        stream_active <= cmd[STREAM_BIT];
                        device_selector <= onehot(rx_data[4:0]);
                        sensor_command <= {1'b0, cmd[6:0]};
                        sensor_start <= 1'b1;
                        state <= ISSUE;
                    end
                end else if (hit) state <= IDLE;
                ISSUE: state <= WAIT_SENSOR;
                WAIT_SENSOR: if (sensor_done || hit) begin
                    code <= sensor_done ? sensor_code : RESP_TIMEOUT;
                    data <= sensor_done ? sensor_data : 8'h00;
                    device_selector <= '0;
                    sensor_command <= '0;
                    state <= SEND_CODE;
                end
                SEND_CODE: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    tx_data <= code;
                    state <= WAIT_CODE;
                end
                // chain straight into the data byte when the transmitter is already free
                WAIT_CODE: if (tx_done) begin
                    tx_start <= !tx_busy;
                    tx_data <= tx_busy ? tx_data : data;
                    state <= tx_busy ? SEND_DATA : WAIT_DATA;
                end
                SEND_DATA: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    tx_data <= data;
                    state <= WAIT_DATA;
                end
                WAIT_DATA: if (tx_done) state <= stream_active ? STREAM_WAIT : IDLE;
                STREAM_WAIT: if (rx_valid) begin
                    stream_active <= 1'b0;
                    cmd <= rx_data;
                    state <= GET_ADDR;
                end else if (hit) begin
                    device_selector <= onehot(addr);
                    sensor_command <= {1'b0, cmd[6:0]};
                    sensor_start <= 1'b1;
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_transaction_sequencer.sv
// tb_transaction_sequencer: directed scoreboard bench for transaction_sequencer
module tb_transaction_sequencer;
    logic clock = 0, reset = 1, rx_valid = 0, sensor_done = 0, tx_busy = 0, tx_done = 0;
    logic [7:0] rx_data = 0, sensor_code = 0, sensor_data = 0;
    logic [31:0] device_selector;
    logic [7:0] sensor_command, tx_data;
    logic sensor_start, tx_start, busy, stream_active, rx_overrun;
    int cyc = 0, checks = 0, passes = 0, fails = 0;
    int tx_count = 0, ss_count = 0, exp_tx = 0, rem = 0, last_rx = 0;
    int s, m, n, t;
    logic [8:0] exp_b;
    logic [8:0] tx_q[$];
    int txc[$];

    transaction_sequencer #(.NUM_DEVICES(32), .TIMEOUT_CYCLES(100), .PERIOD_CYCLES(200)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .device_selector(device_selector), .sensor_command(sensor_command),
        .sensor_start(sensor_start), .sensor_done(sensor_done), .sensor_code(sensor_code),
        .sensor_data(sensor_data), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .busy(busy), .stream_active(stream_active), .rx_overrun(rx_overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int txc_at(input int i);
        return i < txc.size() ? txc[i] : -1;
    endfunction

    task automatic push(input logic [7:0] b);
        tx_q.push_back({1'b0, b});
        exp_tx++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1;
        rx_data = b;
        last_rx = cyc;
        @(negedge clock);
        rx_valid = 0;
    endtask

    task automatic pulse_done(input logic [7:0] c, input logic [7:0] d, output int mc);
        sensor_done = 1;
        sensor_code = c;
        sensor_data = d;
        mc = cyc;
        @(negedge clock);
        sensor_done = 0;
    endtask

    task automatic wait_start(input int bound, output int sc);
        for (int i = 0; i < bound && !sensor_start; i++) @(negedge clock);
        check("sensor_start_seen", 32'(sensor_start), 1);
        sc = cyc;
    endtask

    task automatic wait_quiet(input int bound);
        for (int i = 0; i < bound && (busy || tx_q.size() != 0 || rem != 0); i++) @(negedge clock);
        check("quiet_busy", 32'(busy), 0);
        check("quiet_queue", tx_q.size(), 0);
    endtask

    task automatic check_idle_outputs();
        check("rst_selector", device_selector, 0);
        check("rst_command", 32'(sensor_command), 0);
        check("rst_sensor_start", 32'(sensor_start), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stream", 32'(stream_active), 0);
        check("rst_overrun", 32'(rx_overrun), 0);
    endtask

    // transmitter model and scoreboard consumer: each byte is busy for four cycles
    initial forever begin
        @(negedge clock);
        tx_done = 0;
        if (sensor_start) ss_count++;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                tx_busy = 0;
                tx_done = 1;
            end
        end
        if (tx_start) begin
            if (tx_q.size() > 0) exp_b = tx_q.pop_front();
            else exp_b = 9'h1FF;
            check("tx_byte", 32'(tx_data), 32'(exp_b));
            tx_count++;
            txc.push_back(cyc);
            tx_busy = 1;
            rem = 4;
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check_idle_outputs();
        reset = 0;
        @(negedge clock);

        txc.delete();
        push(8'h08); push(8'h1A);
        send_byte(8'h01); send_byte(8'h03);
        wait_start(50, s);
        check("issue_latency", s, last_rx + 1);
        check("t1_selector", device_selector, 32'h8);
        check("t1_command", 32'(sensor_command), 8'h01);
        check("t1_busy", 32'(busy), 1);
        repeat (9) @(negedge clock);
        pulse_done(8'h08, 8'h1A, m);
        check("t1_selector_clear", device_selector, 0);
        wait_quiet(300);
        check("t1_code_latency", txc_at(0), m + 2);
        check("t1_data_latency", txc_at(1), txc_at(0) + 5);

        txc.delete();
        n = ss_count;
        push(8'hFE); push(8'h00);
        send_byte(8'h01); send_byte(8'h25);
        wait_quiet(300);
        check("badaddr_no_start", ss_count, n);
        check("badaddr_latency", txc_at(0), last_rx + 2);

        txc.delete();
        push(8'hFF); push(8'h00);
        send_byte(8'h02); send_byte(8'h05);
        wait_start(50, s);
        check("t3_selector", device_selector, 32'h20);
        check("t3_command", 32'(sensor_command), 8'h02);
        wait_quiet(400);
        check("timeout_latency", txc_at(0), s + 102);

        txc.delete();
        push(8'h33); push(8'h44);
        send_byte(8'h02); send_byte(8'h06);
        wait_start(50, s);
        repeat (100) @(negedge clock);
        pulse_done(8'h33, 8'h44, m);
        wait_quiet(300);
        check("coincide_latency", txc_at(0), m + 2);

        push(8'h10); push(8'h00);
        send_byte(8'h81); send_byte(8'h00);
        wait_start(50, s);
        check("stream_command", 32'(sensor_command), 8'h01);
        check("stream_set", 32'(stream_active), 1);
        repeat (3) @(negedge clock);
        pulse_done(8'h10, 8'h00, m);
        push(8'h11); push(8'h01);
        wait_start(400, s);
        check("period_latency", s, m + 212);
        check("stream_selector", device_selector, 32'h1);
        repeat (3) @(negedge clock);
        pulse_done(8'h11, 8'h01, m);
        wait_quiet(300);
        check("stream_held", 32'(stream_active), 1);
        n = ss_count;
        push(8'hFD); push(8'h00);
        send_byte(8'h7F);
        check("stream_rx_clears", 32'(stream_active), 0);
        send_byte(8'h00);
        wait_quiet(300);
        check("stop_stream", 32'(stream_active), 0);
        repeat (250) @(negedge clock);
        check("stop_no_reissue", ss_count, n);

        push(8'h55); push(8'h66);
        send_byte(8'h03); send_byte(8'h07);
        wait_start(50, s);
        repeat (2) @(negedge clock);
        send_byte(8'hAA);
        check("overrun_pulse", 32'(rx_overrun), 1);
        @(negedge clock);
        check("overrun_single", 32'(rx_overrun), 0);
        check("overrun_selector", device_selector, 32'h80);
        check("overrun_command", 32'(sensor_command), 8'h03);
        repeat (2) @(negedge clock);
        pulse_done(8'h55, 8'h66, m);
        wait_quiet(300);

        n = ss_count;
        t = tx_count;
        send_byte(8'h01);
        repeat (99) @(negedge clock);
        check("gap_busy_last", 32'(busy), 1);
        @(negedge clock);
        check("gap_idle", 32'(busy), 0);
        repeat (20) @(negedge clock);
        check("gap_no_tx", tx_count, t);
        check("gap_no_start", ss_count, n);

        push(8'h77); push(8'h88);
        send_byte(8'h01); send_byte(8'h02);
        wait_start(50, s);
        repeat (2) @(negedge clock);
        pulse_done(8'h77, 8'h88, m);
        @(negedge clock);
        check("pre_reset_tx", 32'(tx_start), 1);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        check_idle_outputs();
        reset = 0;
        exp_tx -= tx_q.size();
        tx_q.delete();
        n = ss_count;
        t = tx_count;
        repeat (20) @(negedge clock);
        check("post_reset_no_tx", tx_count, t);
        check("post_reset_no_start", ss_count, n);

        txc.delete();
        push(8'hA0); push(8'hA1);
        send_byte(8'h05); send_byte(8'h09);
        wait_start(50, s);
        check("post_reset_issue", s, last_rx + 1);
        check("post_reset_selector", device_selector, 32'h200);
        repeat (4) @(negedge clock);
        pulse_done(8'hA0, 8'hA1, m);
        wait_quiet(300);
        check("post_reset_code_latency", txc_at(0), m + 2);

        check("tx_total", tx_count, exp_tx);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
